// File: rtl/emu_go_ctrl.sv
// Emulator-side run controller: turns go_vio requests into bounded bursts of time steps,
// drives emu_stall/dt_out to the analog models and owns the accumulated emulated time.
module emu_go_ctrl #(
  parameter int unsigned TIME_WIDTH  = 40,
  parameter int unsigned DT_WIDTH    = 32,
  parameter int unsigned STEP_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  emu_clk,
  input  logic                  emu_rst_n,
  input  logic                  go_vio,
  input  logic [1:0]            mode,
  input  logic [DT_WIDTH-1:0]   step_dt,
  input  logic [STEP_WIDTH-1:0] steps_per_go,
  input  logic [TIME_WIDTH-1:0] t_stop,
  output logic                  emu_stall,
  output logic [DT_WIDTH-1:0]   dt_out,
  output logic [TIME_WIDTH-1:0] emu_time,
  output logic                  busy,
  output logic                  done_pulse,
  output logic                  go_overrun,
  output logic                  time_ovf
);

  typedef enum logic [1:0] {
    ModeGoStep = 2'b00,
    ModeFree   = 2'b01,
    ModeUntil  = 2'b10,
    ModeStall  = 2'b11
  } mode_e;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    prev_q, prev_d;
  logic [STEP_WIDTH-1:0]   cnt_q, cnt_d;
  logic [TIME_WIDTH-1:0]   time_q, time_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    overrun_q, overrun_d;
  logic                    ovf_q, ovf_d;

  logic                    synced;
  logic                    go_edge;
  logic                    advance;
  logic [TIME_WIDTH-1:0]   remain;
  logic [TIME_WIDTH-1:0]   step_ext;
  logic [TIME_WIDTH-1:0]   dt_w;
  logic [TIME_WIDTH:0]     sum;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], go_vio};
  assign synced  = sync_q[SYNC_STAGES-1];
  assign prev_d  = synced;
  assign go_edge = synced & ~prev_q;

  always_comb begin
    advance = 1'b0;
    unique case (mode_e'(mode))
      ModeGoStep: advance = (state_q == StRun);
      ModeFree:   advance = 1'b1;
      ModeUntil:  advance = (time_q < t_stop);
      ModeStall:  advance = 1'b0;
      default:    advance = 1'b0;
    endcase
  end

  // In UNTIL mode the last step is clipped so time lands exactly on t_stop.
  assign remain   = t_stop - time_q;
  assign step_ext = TIME_WIDTH'(step_dt);

  always_comb begin
    dt_w = '0;
    if (advance) begin
      if ((mode_e'(mode) == ModeUntil) && (remain < step_ext)) begin
        dt_w = remain;
      end else begin
        dt_w = step_ext;
      end
    end
  end

  assign sum = {1'b0, time_q} + {1'b0, dt_w};

  always_comb begin
    time_d = sum[TIME_WIDTH-1:0];
    ovf_d  = ovf_q;
    if (sum[TIME_WIDTH]) begin
      time_d = '1;
      ovf_d  = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    if ((state_q == StRun) && go_edge) begin
      overrun_d = 1'b1;
    end
    if (mode_e'(mode) != ModeGoStep) begin
      // Leaving GO_STEP aborts any burst silently.
      state_d = StIdle;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (go_edge) begin
            if (steps_per_go != '0) begin
              state_d = StRun;
              cnt_d   = steps_per_go;
              busy_d  = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        StRun: begin
          if (cnt_q == STEP_WIDTH'(1)) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - STEP_WIDTH'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state_q   <= StIdle;
      sync_q    <= '0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      time_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      time_q    <= time_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      ovf_q     <= ovf_d;
    end
  end

  assign emu_stall  = ~advance;
  assign dt_out     = dt_w[DT_WIDTH-1:0];
  assign emu_time   = time_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;
  assign go_overrun = overrun_q;
  assign time_ovf   = ovf_q;

endmodule

// File: tb/tb_emu_go_ctrl.sv
// Self-checking bench for emu_go_ctrl: burst, overrun, zero-step, UNTIL, saturation and abort.
module tb_emu_go_ctrl;
  localparam int TW = 40;
  localparam int DW = 32;
  localparam int SW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          go_vio;
  logic [1:0]    mode;
  logic [DW-1:0] step_dt;
  logic [SW-1:0] steps;
  logic [TW-1:0] t_stop;
  logic          emu_stall, busy, done_pulse, go_overrun, time_ovf;
  logic [DW-1:0] dt_out;
  logic [TW-1:0] emu_time;

  // Narrow instance for the saturation scenario
  logic          go_s = 1'b0;
  logic [1:0]    mode_s;
  logic [7:0]    step_s, t_stop_s, dt_s, time_s;
  logic [SW-1:0] steps_s = '0;
  logic          stall_s, busy_s, done_s, ovr_s, ovf_s;

  emu_go_ctrl u_dut (
    .emu_clk(clk), .emu_rst_n(rst_n), .go_vio(go_vio), .mode(mode), .step_dt(step_dt),
    .steps_per_go(steps), .t_stop(t_stop), .emu_stall(emu_stall), .dt_out(dt_out),
    .emu_time(emu_time), .busy(busy), .done_pulse(done_pulse), .go_overrun(go_overrun),
    .time_ovf(time_ovf)
  );

  emu_go_ctrl #(.TIME_WIDTH(8), .DT_WIDTH(8)) u_small (
    .emu_clk(clk), .emu_rst_n(rst_n), .go_vio(go_s), .mode(mode_s), .step_dt(step_s),
    .steps_per_go(steps_s), .t_stop(t_stop_s), .emu_stall(stall_s), .dt_out(dt_s),
    .emu_time(time_s), .busy(busy_s), .done_pulse(done_s), .go_overrun(ovr_s),
    .time_ovf(ovf_s)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int adv_cnt  = 0;
  int done_cnt = 0;
  logic [TW-1:0] exp_q[$];
  logic [DW-1:0] dt_q[$];
  logic [7:0]    small_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (!emu_stall) adv_cnt++;
      if (done_pulse) done_cnt++;
    end
  end

  task automatic test_reset;
    rst_n = 1'b0; go_vio = 1'b0; mode = 2'b00; step_dt = '0; steps = '0; t_stop = '0;
    mode_s = 2'b11; step_s = '0; t_stop_s = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (emu_time !== '0) begin
      n_fail++; $display("FAIL reset_time: got %0d want 0", emu_time);
    end
    n_checks++;
    if ({busy, done_pulse, go_overrun, time_ovf, emu_stall} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00001",
               {busy, done_pulse, go_overrun, time_ovf, emu_stall});
    end
    n_checks++;
    if (dt_out !== '0) begin
      n_fail++; $display("FAIL reset_dt: got %0d want 0", dt_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (emu_stall !== 1'b1 || emu_time !== '0) begin
      n_fail++; $display("FAIL idle_after_reset: stall %b time %0d want 1 0", emu_stall, emu_time);
    end
  endtask

  task automatic test_go_step;
    int a0, d0, seen;
    logic [TW-1:0] e;
    mode = 2'b00; step_dt = 10; steps = 50;
    a0 = adv_cnt; d0 = done_cnt;
    for (int k = 1; k <= 25; k++) begin
      exp_q.push_back(TW'(500 * k));
      seen = 0;
      go_vio = 1'b1;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (done_pulse && seen == 0) begin
          seen = 1;
          e = exp_q.pop_front();
          n_checks++;
          if (emu_time !== e) begin
            n_fail++; $display("FAIL burst_time[%0d]: got %0d want %0d", k, emu_time, e);
          end
        end
      end
      go_vio = 1'b0;
      repeat (200) @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL burst_done_missing: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (done_cnt - d0 != 25) begin
      n_fail++; $display("FAIL burst_done_count: got %0d want 25", done_cnt - d0);
    end
    n_checks++;
    if (adv_cnt - a0 != 1250) begin
      n_fail++; $display("FAIL burst_adv_cycles: got %0d want 1250", adv_cnt - a0);
    end
    n_checks++;
    if (go_overrun !== 1'b0 || emu_time !== TW'(12500)) begin
      n_fail++; $display("FAIL burst_final: ovr %b time %0d want 0 12500", go_overrun, emu_time);
    end
  endtask

  task automatic test_overrun;
    int a0, seen;
    logic [TW-1:0] e;
    steps = 1000; step_dt = 10;
    exp_q.push_back(emu_time + TW'(10000));
    a0 = adv_cnt; seen = 0;
    for (int i = 0; i < 1400; i++) begin
      go_vio = (i < 200) || (i >= 400 && i < 600);
      @(negedge clk);
      if (done_pulse) begin
        seen++;
        if (seen == 1) begin
          e = exp_q.pop_front();
          n_checks++;
          if (emu_time !== e) begin
            n_fail++; $display("FAIL overrun_time: got %0d want %0d", emu_time, e);
          end
        end
      end
    end
    n_checks++;
    if (seen != 1) begin
      n_fail++; $display("FAIL overrun_done_count: got %0d want 1", seen);
      exp_q.delete();
    end
    n_checks++;
    if (adv_cnt - a0 != 1000) begin
      n_fail++; $display("FAIL overrun_burst_len: got %0d want 1000", adv_cnt - a0);
    end
    n_checks++;
    if (go_overrun !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL overrun_flag: ovr %b busy %b want 1 0", go_overrun, busy);
    end
  endtask

  task automatic test_zero_steps;
    int seen, busy_seen;
    logic [TW-1:0] t0, e;
    steps = 0; t0 = emu_time;
    exp_q.push_back(t0);
    seen = 0; busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      go_vio = (i < 10);
      @(negedge clk);
      if (busy) busy_seen = 1;
      if (done_pulse) begin
        seen++;
        if (seen == 1) begin
          e = exp_q.pop_front();
          n_checks++;
          if (emu_time !== e) begin
            n_fail++; $display("FAIL zero_time: got %0d want %0d", emu_time, e);
          end
        end
      end
    end
    n_checks++;
    if (seen != 1 || busy_seen != 0) begin
      n_fail++; $display("FAIL zero_steps: done %0d busy_seen %0d want 1 0", seen, busy_seen);
      exp_q.delete();
    end
    n_checks++;
    if (emu_time !== t0) begin
      n_fail++; $display("FAIL zero_time_end: got %0d want %0d", emu_time, t0);
    end
  endtask

  task automatic test_until;
    logic [DW-1:0] e;
    rst_n = 1'b0; mode = 2'b10; step_dt = 7; t_stop = 100;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) dt_q.push_back((i < 14) ? DW'(7) : (i == 14) ? DW'(2) : DW'(0));
    for (int i = 0; i < 20; i++) begin
      e = dt_q.pop_front();
      n_checks++;
      if (dt_out !== e || emu_stall !== (e == 0)) begin
        n_fail++;
        $display("FAIL until_dt[%0d]: got dt %0d stall %b want %0d %b", i, dt_out, emu_stall, e,
                 e == 0);
      end
      @(negedge clk);
    end
    n_checks++;
    if (emu_time !== TW'(100)) begin
      n_fail++; $display("FAIL until_time: got %0d want 100", emu_time);
    end
    t_stop = 107;
    #1;
    n_checks++;
    if (emu_stall !== 1'b0 || dt_out !== DW'(7)) begin
      n_fail++; $display("FAIL until_resume: stall %b dt %0d want 0 7", emu_stall, dt_out);
    end
    mode = 2'b11;
    @(negedge clk);
    n_checks++;
    if (emu_time !== TW'(100)) begin
      n_fail++; $display("FAIL until_stall_hold: got %0d want 100", emu_time);
    end
  endtask

  task automatic test_saturate;
    logic [7:0] e;
    n_checks++;
    if (ovf_s !== 1'b0 || time_s !== 8'd0) begin
      n_fail++; $display("FAIL sat_start: ovf %b time %0d want 0 0", ovf_s, time_s);
    end
    mode_s = 2'b01; step_s = 100;
    small_q.push_back(8'd100); small_q.push_back(8'd200); small_q.push_back(8'd255);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = small_q.pop_front();
      n_checks++;
      if (time_s !== e) begin
        n_fail++; $display("FAIL sat_time[%0d]: got %0d want %0d", i, time_s, e);
      end
    end
    n_checks++;
    if (ovf_s !== 1'b1) begin
      n_fail++; $display("FAIL sat_ovf: got %b want 1", ovf_s);
    end
    mode_s = 2'b11;
  endtask

  task automatic test_reset_and_abort;
    int d0;
    logic [TW-1:0] t_hold;
    mode = 2'b00; steps = 1000; step_dt = 10;
    for (int i = 0; i < 60; i++) begin
      go_vio = (i < 10);
      @(negedge clk);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_burst_busy: got %b want 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (emu_time !== '0 || dt_out !== '0) begin
      n_fail++; $display("FAIL async_reset_time: time %0d dt %0d want 0 0", emu_time, dt_out);
    end
    n_checks++;
    if ({busy, done_pulse, go_overrun, time_ovf, emu_stall} !== 5'b00001) begin
      n_fail++;
      $display("FAIL async_reset_flags: got %b want 00001",
               {busy, done_pulse, go_overrun, time_ovf, emu_stall});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      go_vio = (i < 10);
      @(negedge clk);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL fresh_burst_busy: got %b want 1", busy);
    end
    t_hold = emu_time; d0 = done_cnt;
    mode = 2'b11;
    #1;
    n_checks++;
    if (emu_stall !== 1'b1 || dt_out !== '0) begin
      n_fail++; $display("FAIL abort_stall: stall %b dt %0d want 1 0", emu_stall, dt_out);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done_pulse !== 1'b0) begin
      n_fail++; $display("FAIL abort_busy: busy %b done %b want 0 0", busy, done_pulse);
    end
    repeat (30) @(negedge clk);
    n_checks++;
    if (done_cnt != d0 || emu_time !== t_hold) begin
      n_fail++;
      $display("FAIL abort_hold: dones %0d time %0d want 0 %0d", done_cnt - d0, emu_time, t_hold);
    end
    mode = 2'b00;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || emu_stall !== 1'b1) begin
      n_fail++; $display("FAIL abort_idle: busy %b stall %b want 0 1", busy, emu_stall);
    end
  endtask

  initial begin
    test_reset();
    test_go_step();
    test_overrun();
    test_zero_steps();
    test_until();
    test_saturate();
    test_reset_and_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/emu_go_ctrl.md
# emu_go_ctrl

Emulator-side responder to the `go_vio` run pulses issued by the simulation/VIO controller. The block converts each request into a bounded burst of emulator time steps and owns the emulated time base. It drives `emu_stall` and `dt_out` to the analog model blocks and accumulates `emu_time`. It also supports free-run, run-until-time and hard-stall modes, so the host can check analog outputs at deterministic time points.

## Interface

Parameters:
- `TIME_WIDTH`, 40: width of `emu_time` and `t_stop`, unsigned fixed-point time units.
- `DT_WIDTH`, 32: width of `step_dt` and `dt_out`, same time units, with `DT_WIDTH <= TIME_WIDTH`.
- `STEP_WIDTH`, 16: width of `steps_per_go`.
- `SYNC_STAGES`, 2: depth of the `go_vio` synchronizer, minimum 2.

Ports:
- `emu_clk`  in  1  emulator clock.
- `emu_rst_n`  in  1  asynchronous active-low reset.
- `go_vio`  in  1  run request from the VIO/testbench, asynchronous to `emu_clk`, rising-edge significant.
- `mode`  in  2  operating mode: 00 GO_STEP, 01 FREE, 10 UNTIL, 11 STALL.
- `step_dt`  in  DT_WIDTH  nominal time step per advancing cycle.
- `steps_per_go`  in  STEP_WIDTH  number of advancing cycles per `go_vio` rising edge.
- `t_stop`  in  TIME_WIDTH  stop time for UNTIL mode.
- `emu_stall`  out  1  high means the models must hold state this cycle.
- `dt_out`  out  DT_WIDTH  time step applied this cycle; 0 when stalled.
- `emu_time`  out  TIME_WIDTH  accumulated emulated time, registered.
- `busy`  out  1  a GO_STEP burst is in progress.
- `done_pulse`  out  1  one-cycle pulse at the end of a GO_STEP burst.
- `go_overrun`  out  1  sticky; a `go_vio` edge arrived while busy.
- `time_ovf`  out  1  sticky; `emu_time` saturated.

## Operation

- Reset asserted: `emu_time` = 0, `busy` = 0, `done_pulse` = 0, `go_overrun` = 0, `time_ovf` = 0, FSM = IDLE, synchronizer cleared.
  - With FSM in IDLE, `emu_stall` = 1 and `dt_out` = 0 unless `mode` is FREE or UNTIL with `emu_time < t_stop`.
- `go_vio` passes through a `SYNC_STAGES` flop chain.
  - `go_edge` = synced high AND previous synced value low. It is a single-cycle pulse.
- `advance` is combinational from registered state, `mode`, `t_stop` and `emu_time`:
  - GO_STEP: `advance` = (state == RUN).
  - FREE: `advance` = 1.
  - UNTIL: `advance` = (`emu_time < t_stop`).
  - STALL: `advance` = 0.
- `emu_stall` = !`advance`.
- `dt_out` value:
  - `step_dt` when advancing.
  - In UNTIL mode only: `min(step_dt, t_stop - emu_time)`, so time lands exactly on `t_stop`.
  - 0 when not advancing.
- `emu_time` update on each edge: `emu_time <= emu_time + dt_out`.
  - If the sum exceeds `2^TIME_WIDTH - 1`, `emu_time` saturates to all-ones and `time_ovf` is set.
- FSM (GO_STEP mode only; in any other mode the FSM is forced to IDLE):
  - IDLE:
    - `go_edge` with `steps_per_go` != 0: load `cnt <= steps_per_go`, go to RUN, `busy` = 1.
    - `go_edge` with `steps_per_go` == 0: stay in IDLE, assert `done_pulse` next cycle, no time advance.
  - RUN: each cycle `cnt` decrements. When `cnt` == 1, go to IDLE, `busy` = 0 and `done_pulse` = 1, registered together.
  - `go_edge` while in RUN: ignored (not queued) and `go_overrun` is set.
  - `mode` leaving GO_STEP while in RUN: abort to IDLE next edge, `busy` = 0, no `done_pulse`, `cnt` discarded.
- `steps_per_go` is sampled only at burst start. Changing it mid-burst has no effect.
- Async reset mid-burst: all state returns to reset values immediately. Elapsed time is lost.

## Timing

- Edge E0 is the first `emu_clk` edge that samples `go_vio` high.
  - `go_edge` is high during cycle E(SYNC_STAGES-1) to E(SYNC_STAGES).
  - FSM enters RUN at E(SYNC_STAGES).
  - `emu_stall` goes low after E(SYNC_STAGES), which is 2 cycles for the default depth.
- A burst gives exactly `steps_per_go` consecutive cycles with `emu_stall` = 0.
  - `emu_time` rises by `steps_per_go * step_dt`, visible one edge after the last advancing cycle.
  - `done_pulse` is high in the first cycle after the burst, concurrent with `busy` = 0.
- Back-to-back: a `go_edge` in the same cycle that `done_pulse` is high is accepted. The FSM is IDLE at that point, so no overrun is flagged.
- `go_vio` high pulses must last at least `SYNC_STAGES + 1` `emu_clk` periods. Shorter pulses may be missed.
- UNTIL: the cycle with `emu_time == t_stop` has `emu_stall` = 1.
  - Raising `t_stop` resumes advance the same cycle (combinational).

## Test plan

- Reset, then GO_STEP mode with `step_dt`=10 and `steps_per_go`=50, 25 `go_vio` pulses each 2 us high / 2 us low at `emu_clk` 100 MHz:
  - `emu_time` = 500·k after pulse k, ending at 12500.
  - 25 `done_pulse`s, `go_overrun` = 0.
  - Exactly 1250 cycles with `emu_stall` = 0.
- `go_vio` pulse during a burst with `steps_per_go`=1000: burst length stays 1000, `go_overrun` = 1, only one `done_pulse`.
- UNTIL with `step_dt`=7 and `t_stop`=100 from `emu_time`=0:
  - 14 cycles of 7, then `dt_out`=2.
  - `emu_time` settles at exactly 100 and `emu_stall` stays 1 thereafter.
- `emu_time` preloaded near max (FREE mode, `TIME_WIDTH`=8, `step_dt`=100): after 3 cycles `emu_time`=255 and `time_ovf`=1.
- `steps_per_go`=0: one `done_pulse`, `emu_time` unchanged, `busy` never high.
- `emu_rst_n` low mid-burst, then `mode` switched to STALL mid-burst after a fresh burst:
  - Reset: all outputs go to reset values immediately.
  - STALL switch: abort with no `done_pulse`, `emu_stall`=1, `busy`=0 next cycle.
